gain_control_panel: RTL and testbench

User-input front end for the 8-band equalizer. It debounces three raw push-buttons (up, down, next-band) and tracks which band is selected. It produces the single-cycle `inc`/`dec` strobes that drive the per-band amplifiers, saturating at the same 0..3 gain limits. It also keeps a shadow copy of every band's gain factor for display logic.

---
 rtl/gain_control_panel.sv | 251 +++++++++++++++++++++++++
 tb/tb_gain_control_panel.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_control_panel.sv
// ---------------------------------------------------------------------------
// gain_control_panel
//
// This is the front end for the 8-band equalizer's push-buttons. It takes three
// raw buttons (up, down, next-band) and passes each one through a two-flop
// synchronizer and a debouncer. The debounced levels then drive:
//   - the band selector, and
//   - the up/down strobe generator.
// The up/down strobes are one-hot, single-cycle pulses. They are gated so the
// gain of the selected band stays within 0..3. A shadow copy of every band's
// gain is kept here so the display logic can read it.
//
// Optional feature macro: GAIN_CTRL_AUTOREPEAT_EN
//   defined   : a held up/down button auto-repeats. The first repeat comes
//               REPEAT_DELAY cycles after the first strobe. Later repeats are
//               spaced REPEAT_PERIOD cycles apart.
//   undefined : each accepted press gives exactly one strobe, however long
//               the button is held.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   btn_up      in   raw up button, active-high
//   btn_down    in   raw down button, active-high
//   btn_next    in   raw next-band button, active-high
//   inc         out  one-hot increment strobe, bit b drives amplifier b
//   dec         out  one-hot decrement strobe, bit b drives amplifier b
//   band_sel    out  currently selected band
//   gain_shadow out  band b's gain factor in bits [2b+1:2b]
// ---------------------------------------------------------------------------
module gain_control_panel #(
    parameter int NUM_BANDS       = 8,
    parameter int DEFAULT_FACTOR  = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_next,
    output logic [NUM_BANDS-1:0]   inc,
    output logic [NUM_BANDS-1:0]   dec,
    output logic [BW-1:0]          band_sel,
    output logic [2*NUM_BANDS-1:0] gain_shadow
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);

    // Bit 0 = up, bit 1 = down, bit 2 = next
    logic [2:0]     w_raw;
    logic [2:0]     r_syncA;
    logic [2:0]     r_syncB;
    logic [2:0]     r_level;
    logic [2:0]     r_levelPrev;
    logic [2:0]     w_rise;
    logic [DCW-1:0] r_dbCount [3];

    logic [1:0]     r_gain [NUM_BANDS];
    logic [1:0]     w_curGain;
    logic           w_reqUp;
    logic           w_reqDown;
    logic           w_issueUp;
    logic           w_issueDown;

    assign w_raw  = {btn_next, btn_down, btn_up};
    assign w_rise = r_level & ~r_levelPrev;

    // Two-flop synchronizer for the asynchronous buttons. Also keeps a
    // one-cycle-delayed copy of the accepted levels so rising edges can be
    // detected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_syncA     <= '0;
            r_syncB     <= '0;
            r_levelPrev <= '0;
        end else begin
            r_syncA     <= w_raw;
            r_syncB     <= r_syncA;
            r_levelPrev <= r_level;
        end
    end

    // Debouncer. While the synchronized sample disagrees with the accepted
    // level, a counter runs. The count starts again whenever they agree. The
    // level flips only when the count reaches DEBOUNCE_CYCLES, so a change is
    // accepted only after enough consecutive stable samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
            for (int i = 0; i < 3; i++) begin
                r_dbCount[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_syncB[i] == r_level[i]) begin
                    r_dbCount[i] <= '0;
                end else if (r_dbCount[i] == DCW'(DEBOUNCE_CYCLES)) begin
                    r_level[i]   <= r_syncB[i];
                    r_dbCount[i] <= '0;
                end else begin
                    r_dbCount[i] <= r_dbCount[i] + DCW'(1);
                end
            end
        end
    end

    // Band selector. It steps once per accepted next-band press and wraps
    // around to band 0 after the last band.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            band_sel <= '0;
        end else if (w_rise[2]) begin
            if (band_sel == BW'(NUM_BANDS - 1)) begin
                band_sel <= '0;
            end else begin
                band_sel <= band_sel + BW'(1);
            end
        end
    end

`ifdef GAIN_CTRL_AUTOREPEAT_EN
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_REPEAT
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [TW-1:0]  r_timer;
    logic [TW-1:0]  w_timerNext;
    logic           r_dirDown;
    logic           w_dirNext;
    logic           w_activeLevel;

    assign w_activeLevel = r_dirDown ? r_level[1] : r_level[0];

    // Auto-repeat state, hold timer and latched direction. The timer counts
    // the cycles since the last strobe request. It keeps running even when a
    // strobe is suppressed at the gain limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_dirDown <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_timer   <= w_timerNext;
            r_dirDown <= w_dirNext;
        end
    end

    // Next-state and strobe-request logic.
    // In IDLE, a rising edge on one button starts a hold, but only if the
    // other button is not also accepted high. Once a hold has started, only
    // releasing the latched button ends it; the other button is ignored.
    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        w_dirNext   = r_dirDown;
        w_reqUp     = 1'b0;
        w_reqDown   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timerNext = '0;
                if (w_rise[0] && !r_level[1]) begin
                    w_reqUp     = 1'b1;
                    w_dirNext   = 1'b0;
                    w_stateNext = S_WAIT;
                end else if (w_rise[1] && !r_level[0]) begin
                    w_reqDown   = 1'b1;
                    w_dirNext   = 1'b1;
                    w_stateNext = S_WAIT;
                end
            end
            S_WAIT, S_REPEAT: begin
                if (!w_activeLevel) begin
                    w_stateNext = S_IDLE;
                    w_timerNext = '0;
                end else if (((r_state == S_WAIT) && (r_timer == TW'(REPEAT_DELAY - 1))) ||
                             ((r_state == S_REPEAT) && (r_timer == TW'(REPEAT_PERIOD - 1)))) begin
                    w_reqUp     = !r_dirDown;
                    w_reqDown   = r_dirDown;
                    w_stateNext = S_REPEAT;
                    w_timerNext = '0;
                end else begin
                    w_timerNext = r_timer + TW'(1);
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_timerNext = '0;
            end
        endcase
    end
`else
    // Without auto-repeat the repeat timing parameters have no effect; this
    // empty block only keeps them referenced.
    if (REPEAT_DELAY > 0 && REPEAT_PERIOD > 0) begin : g_repeatUnused
    end

    // One strobe request per accepted press. Pressing both buttons together
    // requests nothing.
    always_comb begin
        w_reqUp   = w_rise[0] && !r_level[1];
        w_reqDown = w_rise[1] && !r_level[0];
    end
`endif

    assign w_curGain   = r_gain[band_sel];
    assign w_issueUp   = w_reqUp && (w_curGain != 2'd3);
    assign w_issueDown = w_reqDown && (w_curGain != 2'd0);

    // Strobe outputs and the shadow gains. A strobe that is issued moves the
    // selected band's shadow by one step on the same edge that registers
    // the strobe, so the shadow and the amplifier never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc <= '0;
            dec <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                r_gain[b] <= 2'(DEFAULT_FACTOR);
            end
        end else begin
            inc <= '0;
            dec <= '0;
            if (w_issueUp) begin
                inc              <= NUM_BANDS'(1) << band_sel;
                r_gain[band_sel] <= w_curGain + 2'd1;
            end else if (w_issueDown) begin
                dec              <= NUM_BANDS'(1) << band_sel;
                r_gain[band_sel] <= w_curGain - 2'd1;
            end
        end
    end

    // Flatten the shadow gains onto the display bus.
    always_comb begin
        gain_shadow = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            gain_shadow[2*b +: 2] = r_gain[b];
        end
    end

endmodule

// File: tb/tb_gain_control_panel.sv
module tb_gain_control_panel;

    localparam int NB  = 8;
    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int DEF = 1;
`ifdef GAIN_CTRL_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    localparam int K_UP = 0, K_DOWN = 1, K_NEXT = 2, K_BOTH = 3, K_BOUNCE = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            btnUp;
    logic            btnDown;
    logic            btnNext;
    logic [NB-1:0]   inc;
    logic [NB-1:0]   dec;
    logic [2:0]      bandSel;
    logic [2*NB-1:0] gainShadow;

    gain_control_panel #(
        .NUM_BANDS      (NB),
        .DEFAULT_FACTOR (DEF),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_up     (btnUp),
        .btn_down   (btnDown),
        .btn_next   (btnNext),
        .inc        (inc),
        .dec        (dec),
        .band_sel   (bandSel),
        .gain_shadow(gainShadow)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge number n it holds n
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              t;
        logic [NB-1:0]   inc;
        logic [NB-1:0]   dec;
        logic [2*NB-1:0] shadow;
    } exp_t;

    exp_t expQ[$];
    int   modelGain[NB];
    int   modelBand;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [2*NB-1:0] packGains();
        logic [2*NB-1:0] v;
        v = '0;
        for (int b = 0; b < NB; b++) v[2*b +: 2] = 2'(modelGain[b]);
        return v;
    endfunction

    function automatic void modelReset();
        for (int b = 0; b < NB; b++) modelGain[b] = DEF;
        modelBand = 0;
        expQ.delete();
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model of a hold. The press is first sampled at edge c0 and
    // the button is released for edges c0+len onward. The first strobe comes
    // 3+DB edges after the press. Repeats follow RD later and then every RP.
    // No strobe can come later than 2+DB edges after the release, and none
    // later than edge 'limit'.
    function automatic void predictHold(input bit down, input int c0, input int len, input int limit);
        int   t;
        int   bound;
        bit   first;
        exp_t e;
        t     = c0 + 3 + DB;
        bound = c0 + len + 2 + DB;
        if (limit < bound) bound = limit;
        first = 1'b1;
        while (t <= bound) begin
            if (down ? (modelGain[modelBand] > 0) : (modelGain[modelBand] < 3)) begin
                modelGain[modelBand] += down ? -1 : 1;
                e.t      = t;
                e.inc    = down ? '0 : NB'(1) << modelBand;
                e.dec    = down ? NB'(1) << modelBand : '0;
                e.shadow = packGains();
                expQ.push_back(e);
            end
            if (!AUTOREP) break;
            t     += first ? RD : RP;
            first  = 1'b0;
        end
    endfunction

    task automatic checkResetState();
        checkOutput("rstInc", inc, 0);
        checkOutput("rstDec", dec, 0);
        checkOutput("rstBand", bandSel, 0);
        checkOutput("rstShadow", gainShadow, packGains());
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        modelReset();
        checkResetState();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setButtons(input int kind, input bit v);
        case (kind)
            K_UP:     btnUp = v;
            K_DOWN:   btnDown = v;
            K_NEXT:   btnNext = v;
            K_BOTH:   begin btnUp = v; btnDown = v; end
            default:  btnUp = v;
        endcase
    endtask

    // Drive one action for len cycles, then let everything settle for gap cycles
    task automatic applyStimulus(input int kind, input int len, input int gap);
        int c0;
        @(negedge clk);
        c0 = cyc + 1;
        if (kind == K_BOUNCE) begin
            for (int i = 0; i < len; i++) begin
                btnUp = ((i / 2) % 2) == 0;
                @(negedge clk);
            end
            btnUp = 1'b0;
        end else begin
            setButtons(kind, 1'b1);
            if (kind == K_UP)   predictHold(1'b0, c0, len, 1 << 30);
            if (kind == K_DOWN) predictHold(1'b1, c0, len, 1 << 30);
            repeat (len) @(negedge clk);
            setButtons(kind, 1'b0);
            if (kind == K_NEXT) modelBand = (modelBand + 1) % NB;
        end
        repeat (gap) @(negedge clk);
        checkOutput("band", bandSel, modelBand);
        checkOutput("shadow", gainShadow, packGains());
    endtask

    // Hold a button, assert reset after 'pre' cycles, release reset while
    // still holding, then hold for 'post' more cycles.
    task automatic resetDuringHold(input bit down, input int pre, input int post, input int gap);
        int c0;
        @(negedge clk);
        c0 = cyc + 1;
        if (down) btnDown = 1'b1; else btnUp = 1'b1;
        predictHold(down, c0, 1 << 20, c0 + pre - 1);
        repeat (pre) @(negedge clk);
        rst = 1'b1;
        #1;
        modelReset();
        checkResetState();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        c0 = cyc + 1;
        predictHold(down, c0, post, 1 << 30);
        repeat (post) @(negedge clk);
        btnUp   = 1'b0;
        btnDown = 1'b0;
        repeat (gap) @(negedge clk);
        checkOutput("band", bandSel, modelBand);
        checkOutput("shadow", gainShadow, packGains());
    endtask

    // Monitor: pops an expected strobe whenever one shows up, and flags any
    // strobe that is unexpected or missing.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if ((inc != '0) || (dec != '0)) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpectedStrobe: inc=%0h dec=%0h at edge %0d, none expected", inc, dec, cyc);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("strobeEdge", cyc, e.t);
                        checkOutput("strobeInc", inc, e.inc);
                        checkOutput("strobeDec", dec, e.dec);
                        checkOutput("strobeShadow", gainShadow, e.shadow);
                    end
                end else if ((expQ.size() > 0) && (expQ[0].t <= cyc)) begin
                    e = expQ.pop_front();
                    checks++;
                    errors++;
                    $display("[TB] FAIL missingStrobe: got none at edge %0d, expected inc=%0h dec=%0h at edge %0d", cyc, e.inc, e.dec, e.t);
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        btnUp   = 1'b0;
        btnDown = 1'b0;
        btnNext = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkResetState();
        rst = 1'b0;

        // Single press on band 0: one inc at press edge +7, gain 1 -> 2
        applyStimulus(K_UP, 8, 14);
        // Bouncing button is never accepted
        applyStimulus(K_BOUNCE, 30, 14);
        // Long hold from default gain: saturates at 3
        doReset();
        applyStimulus(K_UP, 200, 14);
        // Walk the band selector all the way round
        for (int i = 0; i < 8; i++) applyStimulus(K_NEXT, 6, 10);
        for (int i = 0; i < 7; i++) applyStimulus(K_NEXT, 6, 10);
        // Down on band 7 down to 0, then a suppressed press
        applyStimulus(K_DOWN, 8, 14);
        applyStimulus(K_DOWN, 8, 14);
        // Both buttons together produce nothing
        applyStimulus(K_BOTH, 40, 14);
        // Reset in the middle of an auto-repeat hold
        resetDuringHold(1'b0, 32, 20, 14);
        // Band 1 to gain 3, then a long down hold
        applyStimulus(K_NEXT, 6, 10);
        applyStimulus(K_UP, 8, 14);
        applyStimulus(K_UP, 8, 14);
        applyStimulus(K_DOWN, 200, 14);

        // Randomized actions
        for (int n = 0; n < 40; n++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 4);
            case (kind)
                K_UP, K_DOWN: len = $urandom_range(6, 70);
                K_NEXT:       len = $urandom_range(6, 10);
                K_BOTH:       len = $urandom_range(8, 30);
                default:      len = 30;
            endcase
            applyStimulus(kind, len, $urandom_range(12, 20));
        end

        repeat (4) @(negedge clk);
        checkOutput("queueEmpty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
